// File: rtl/alu_pkg.sv
// Shared encodings and sizes for the ALU operation sequencer and its adder path.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 6;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULU = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/cla_adder.sv
// 32-bit adder with 4-bit generate/propagate groups and lookahead carries between groups.
// sign flags two's-complement overflow when unsign=0 and is held low for unsigned adds.
module cla_adder (
  input  logic [31:0] A,
  input  logic [31:0] D,
  input  logic        Cnt,
  input  logic        unsign,
  output logic [31:0] S,
  output logic        Cout,
  output logic        sign
);

  logic [31:0] g, p;
  logic [7:0]  gg, pg;
  logic [32:0] c;

  assign g = A & D;
  assign p = A ^ D;

  always_comb begin
    gg = '0;
    pg = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
              (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
  end

  // Group carry-outs come from the group G/P terms, not from the last ripple bit.
  always_comb begin
    c    = '0;
    c[0] = Cnt;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
    end
  end

  assign S    = p ^ c[31:0];
  assign Cout = c[32];
  assign sign = ~unsign & (A[31] == D[31]) & (S[31] != A[31]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one shared cla_adder for ADD/SUB and a 32-iteration shift-add MULU.
// Build option ALU_MUL_ZERO_SKIP_EN: MULU with a zero operand finishes in one cycle.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = alu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              unsign_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic              carry_out,
  output logic              ovf,
  output logic              err
);

  state_e            state, state_nxt;
  op_e               op_q;
  logic [DATA_W-1:0] mcand_q, lo_q, hi_q;
  logic              uns_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept, zero_skip, mul_last;
  logic [DATA_W-1:0] add_a, add_d, add_s;
  logic              add_cin, add_uns, add_cout, add_sign;
  logic              mul_c;
  logic [DATA_W-1:0] mul_s, hi_nxt, lo_nxt;

  assign start_ready = rst_n & (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign accept      = start_valid & start_ready;
  assign mul_last    = (cnt_q == CNT_W'(MUL_ITERS - 1));

`ifdef ALU_MUL_ZERO_SKIP_EN
  assign zero_skip = (op_e'(op) == OP_MULU) && ((opa == '0) || (opb == '0));
`else
  assign zero_skip = 1'b0;
`endif

  // Operand A register doubles as the multiplicand; lo_q holds opb, then the shifting multiplier.
  always_comb begin
    add_a   = mcand_q;
    add_d   = lo_q;
    add_cin = 1'b0;
    add_uns = uns_q;
    if (state == S_MUL) begin
      add_a   = hi_q;
      add_d   = mcand_q;
      add_uns = 1'b1;
    end else if (op_q == OP_SUB) begin
      add_d   = ~lo_q;
      add_cin = 1'b1;
    end
  end

  cla_adder u_add (
    .A      (add_a),
    .D      (add_d),
    .Cnt    (add_cin),
    .unsign (add_uns),
    .S      (add_s),
    .Cout   (add_cout),
    .sign   (add_sign)
  );

  assign mul_c  = lo_q[0] & add_cout;
  assign mul_s  = lo_q[0] ? add_s : hi_q;
  assign hi_nxt = {mul_c, mul_s[DATA_W-1:1]};
  assign lo_nxt = {mul_s[0], lo_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept)
                state_nxt = (op_e'(op) == OP_MULU && !zero_skip) ? S_MUL : S_EXEC;
      S_EXEC: state_nxt = S_DONE;
      S_MUL:  if (mul_last) state_nxt = S_DONE;
      S_DONE: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      mcand_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      uns_q     <= 1'b0;
      cnt_q     <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q    <= op_e'(op);
          mcand_q <= opa;
          lo_q    <= opb;
          hi_q    <= '0;
          uns_q   <= unsign_in;
          cnt_q   <= '0;
          err     <= 1'b0;
        end
        S_EXEC: begin
          res_hi <= '0;
          err    <= (op_q == OP_RSVD);
          // A skipped MULU lands here too and yields an all-zero product.
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            res_lo    <= add_s;
            carry_out <= add_cout;
            ovf       <= add_sign;
          end else begin
            res_lo    <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        S_MUL: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            res_hi    <= hi_nxt;
            res_lo    <= lo_nxt;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized checks of alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0, opb = '0;
  logic        unsign_in = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_lo, res_hi;
  logic        carry_out, ovf, err;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        c;
    logic        v;
    logic        e;
  } res_t;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .opa(opa), .opb(opb), .unsign_in(unsign_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lo(res_lo), .res_hi(res_hi),
    .carry_out(carry_out), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b, logic u);
    res_t        r;
    logic [32:0] s;
    logic [31:0] bd;
    r = '0;
    case (o)
      2'b00, 2'b01: begin
        bd   = (o == 2'b01) ? ~b : b;
        s    = {1'b0, a} + {1'b0, bd} + 33'(o == 2'b01);
        r.lo = s[31:0];
        r.c  = s[32];
        r.v  = !u && (a[31] == bd[31]) && (s[31] != a[31]);
      end
      2'b10:   {r.hi, r.lo} = 64'(a) * 64'(b);
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    if (o != 2'b10) return 1;
`ifdef ALU_MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return 32;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_res(input string tag, input res_t r);
    chk({tag, "_lo"}, 64'(res_lo), 64'(r.lo));
    chk({tag, "_hi"}, 64'(res_hi), 64'(r.hi));
    chk({tag, "_c"},  64'(carry_out), 64'(r.c));
    chk({tag, "_v"},  64'(ovf), 64'(r.v));
    chk({tag, "_e"},  64'(err), 64'(r.e));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lo"}, 64'(res_lo), 64'd0);
    chk({tag, "_hi"}, 64'(res_hi), 64'd0);
    chk({tag, "_flags"}, 64'({carry_out, ovf, err}), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_ready"}, 64'(start_ready), 64'd0);
  endtask

  // Issue one op, wait for the result, optionally stall in DONE, then hand it off.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic u, input int stall);
    res_t r;
    int   lat;
    r = model(o, a, b, u);
    @(negedge clk);
    chk({tag, "_rdy_idle"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1; op = o; opa = a; opb = b; unsign_in = u;
    @(posedge clk); #1;
    start_valid = 1'b0;
    opa = $urandom; opb = $urandom; op = 2'($urandom); unsign_in = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(o, a, b)));
    chk_res(tag, r);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      start_valid = 1'($urandom); opa = $urandom; opb = $urandom; op = 2'($urandom);
      @(posedge clk); #1;
      chk({tag, "_stall_vld"}, 64'(res_valid), 64'd1);
      chk({tag, "_stall_rdy"}, 64'(start_ready), 64'd0);
      chk_res({tag, "_stall"}, r);
    end
    @(negedge clk);
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_hs_vld"}, 64'(res_valid), 64'd0);
    chk({tag, "_hs_rdy"}, 64'(start_ready), 64'd1);
    chk({tag, "_hs_keep"}, 64'(res_lo), 64'(r.lo));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",   2'b00, 32'h0077_8866, 32'h0055_4433, 1'b1, 0);
    chk("add_const", 64'(res_lo), 64'h00CC_CC99);
    run_op("sub57", 2'b01, 32'd5, 32'd7, 1'b0, 0);
    chk("sub57_const", 64'({carry_out, res_lo}), 64'h0_FFFF_FFFE);
    run_op("sub75", 2'b01, 32'd7, 32'd5, 1'b0, 0);
    chk("sub75_const", 64'({carry_out, res_lo}), 64'h1_0000_0002);
    run_op("mulmax", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    chk("mulmax_const", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mulbp", 2'b10, 32'h0077_8866, 32'h0055_4433, 1'b0, 5);
    run_op("rsvd",  2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0);
    run_op("errclr", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op("mulzero", 2'b10, 32'h0, 32'h1234, 1'b0, 0);

    // Abort a multiply mid-flight with reset.
    @(negedge clk);
    start_valid = 1'b1; op = 2'b10; opa = 32'hDEAD_BEEF; opb = 32'h0000_0003;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst", 2'b00, 32'd1, 32'd1, 1'b0, 0);
    chk("postrst_const", 64'(res_lo), 64'd2);

    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      run_op("rand", ro, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
